// File: rtl/snn_inference_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : snn_inference_sequencer
//  Purpose  : Loads signed pixels, rate-encodes them into positive/negative
//             spike vectors with an LFSR, accumulates the layer's net output
//             spikes over a fixed window and reports the argmax class.
//  Revision : 1.0 - initial release
// ============================================================================
module snn_inference_sequencer #(
    parameter int         NUM_IN    = 16,
    parameter int         NUM_OUT   = 10,
    parameter int         PIX_W     = 8,
    parameter int         NUM_STEPS = 64,
    parameter int         LAYER_LAT = 1,
    parameter int         CNT_W     = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [PIX_W-1:0]           pix_data,
    output logic                       layer_clear,
    output logic [NUM_IN-1:0]          pos_spike,
    output logic [NUM_IN-1:0]          neg_spike,
    input  logic [NUM_OUT-1:0]         layer_pos,
    input  logic [NUM_OUT-1:0]         layer_neg,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_OUT)-1:0] class_out,
    output logic [CNT_W-1:0]           class_score
);

    localparam int c_IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int c_STEP_W = $clog2(NUM_STEPS + 1);
    localparam int c_DR_W   = (LAYER_LAT > 1) ? $clog2(LAYER_LAT) : 1;
    localparam int c_K_W    = $clog2(NUM_OUT);
    localparam int c_MAG_W  = PIX_W - 1;

    localparam logic [c_IDX_W-1:0]      c_LAST_IDX  = c_IDX_W'(NUM_IN - 1);
    localparam logic [c_STEP_W-1:0]     c_LAST_STEP = c_STEP_W'(NUM_STEPS - 1);
    localparam logic [c_STEP_W-1:0]     c_LAT_STEP  = c_STEP_W'(LAYER_LAT);
    localparam logic [c_DR_W-1:0]       c_LAST_DR   = c_DR_W'(LAYER_LAT - 1);
    localparam logic [c_K_W-1:0]        c_LAST_K    = c_K_W'(NUM_OUT - 1);
    localparam logic [c_MAG_W-1:0]      c_MAG_ONE   = c_MAG_W'(1);
    localparam logic signed [CNT_W-1:0] c_S_ONE     = CNT_W'(1);
    localparam logic signed [CNT_W-1:0] c_SMAX      = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] c_SMIN      = {1'b1, {(CNT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CLEAR  = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_ARGMAX = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [PIX_W-1:0]           r_pixel [NUM_IN];
    logic [c_IDX_W-1:0]         r_idx;
    logic [c_STEP_W-1:0]        r_step;
    logic [c_DR_W-1:0]          r_drain;
    logic [c_K_W-1:0]           r_k;
    logic [7:0]                 r_lfsr;
    logic signed [CNT_W-1:0]    r_score     [NUM_OUT];
    logic signed [CNT_W-1:0]    w_score_nxt [NUM_OUT];
    logic signed [CNT_W-1:0]    r_best_score;
    logic [c_K_W-1:0]           r_best_idx;
    logic [c_K_W-1:0]           r_class_out;
    logic signed [CNT_W-1:0]    r_class_score;
    logic                       w_run;
    logic                       w_win;
    logic                       w_take;
    logic signed [CNT_W-1:0]    w_cand;
    logic signed [CNT_W-1:0]    w_new_score;
    logic [c_K_W-1:0]           w_new_idx;

    assign w_run       = (r_state == S_RUN);
    // Counting window is the spike window shifted by the layer latency.
    assign w_win       = (w_run && (r_step >= c_LAT_STEP)) || (r_state == S_DRAIN);
    assign class_out   = r_class_out;
    assign class_score = r_class_score;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic and state-decoded control outputs.
    always_comb begin
        w_state_nxt = r_state;
        pix_ready   = 1'b0;
        layer_clear = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid && (r_idx == c_LAST_IDX)) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                layer_clear = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN:    if (r_step == c_LAST_STEP) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (r_drain == c_LAST_DR)  w_state_nxt = S_ARGMAX;
            S_ARGMAX: if (r_k == c_LAST_K)       w_state_nxt = S_DONE;
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Phase counters; each wraps to zero as its phase ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_step  <= '0;
            r_drain <= '0;
            r_k     <= '0;
        end else begin
            if ((r_state == S_LOAD) && pix_valid)
                r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
            if (w_run)
                r_step <= (r_step == c_LAST_STEP) ? '0 : r_step + 1'b1;
            if (r_state == S_DRAIN)
                r_drain <= (r_drain == c_LAST_DR) ? '0 : r_drain + 1'b1;
            if (r_state == S_ARGMAX)
                r_k <= (r_k == c_LAST_K) ? '0 : r_k + 1'b1;
        end
    end

    // Pixel store, filled in arrival order during LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_IN; i++) r_pixel[i] <= '0;
        end else if ((r_state == S_LOAD) && pix_valid) begin
            r_pixel[r_idx] <= pix_data;
        end
    end

    // Fibonacci LFSR (taps 8,6,5,4): seeded per inference, steps once per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_lfsr <= LFSR_SEED;
        else if ((r_state == S_IDLE) && start)
            r_lfsr <= LFSR_SEED;
        else if (w_run)
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    // Rate encoder: one comparator per input against an index-scrambled LFSR value.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_enc
        localparam logic [c_MAG_W-1:0] c_OFFS = c_MAG_W'(gi);
        logic               w_sgn;
        logic [c_MAG_W-1:0] w_low;
        logic [c_MAG_W-1:0] w_negm;
        logic [c_MAG_W-1:0] w_mag;
        logic [c_MAG_W-1:0] w_rnd;
        logic               w_spk;

        assign w_sgn  = r_pixel[gi][PIX_W-1];
        assign w_low  = r_pixel[gi][c_MAG_W-1:0];
        assign w_negm = ~w_low + c_MAG_ONE;
        // Most negative value has zero low bits; saturate it to full-scale magnitude.
        assign w_mag  = !w_sgn ? w_low : ((w_low == '0) ? '1 : w_negm);
        assign w_rnd  = r_lfsr[c_MAG_W-1:0] ^ c_OFFS;
        assign w_spk  = w_run && (w_mag > w_rnd);
        assign pos_spike[gi] = w_spk & ~w_sgn;
        assign neg_spike[gi] = w_spk &  w_sgn;
    end

    // Saturating net increment per class; simultaneous pos/neg cancels.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            w_score_nxt[k] = r_score[k];
            if (layer_pos[k] && !layer_neg[k] && (r_score[k] != c_SMAX))
                w_score_nxt[k] = r_score[k] + c_S_ONE;
            else if (!layer_pos[k] && layer_neg[k] && (r_score[k] != c_SMIN))
                w_score_nxt[k] = r_score[k] - c_S_ONE;
        end
    end

    // Score accumulators: zeroed in CLEAR, updated only inside the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_OUT; k++) r_score[k] <= '0;
        end else if (r_state == S_CLEAR) begin
            for (int k = 0; k < NUM_OUT; k++) r_score[k] <= '0;
        end else if (w_win) begin
            r_score <= w_score_nxt;
        end
    end

    // First entry always seeds the running best; later ones replace it only if strictly greater.
    assign w_cand      = r_score[r_k];
    assign w_take      = (r_k == '0) || (w_cand > r_best_score);
    assign w_new_score = w_take ? w_cand : r_best_score;
    assign w_new_idx   = w_take ? r_k    : r_best_idx;

    // Serial argmax scan; the result is published as the FSM enters DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_best_score  <= '0;
            r_best_idx    <= '0;
            r_class_out   <= '0;
            r_class_score <= '0;
        end else if (r_state == S_ARGMAX) begin
            r_best_score <= w_new_score;
            r_best_idx   <= w_new_idx;
            if (r_k == c_LAST_K) begin
                r_class_out   <= w_new_idx;
                r_class_score <= w_new_score;
            end
        end
    end

endmodule
`default_nettype wire
